// File: rtl/sramgen_sram_masked_v2.sv
// Single-port SRAM with per-group write mask and a post-reset zero-fill sequence.
// Optional macro SRAMGEN_X_ON_WRITE_EN: drive dout to all-X on every IDLE write cycle.
module sramgen_sram_masked_v2 #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int WMASK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   busy
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  // Guarded divisor keeps elaboration alive long enough to hit the fatal check below.
  localparam int WG = DATA_WIDTH / ((WMASK_WIDTH < 1) ? 1 : WMASK_WIDTH);

  if ((WMASK_WIDTH < 1) || ((DATA_WIDTH % ((WMASK_WIDTH < 1) ? 1 : WMASK_WIDTH)) != 0)) begin : g_bad_cfg
    $fatal(1, "sramgen_sram_masked_v2: DATA_WIDTH must be a multiple of WMASK_WIDTH >= 1");
  end

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
  logic [WMASK_WIDTH-1:0]  mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    dout_d     = dout_q;
    mem_we     = '0;
    mem_addr   = addr;
    mem_wdata  = din;

    case (state_q)
      CLEAR: begin
        mem_we     = '1;
        mem_addr   = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        dout_d     = '0;
        if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (en) begin
          if (we) begin
            mem_we = wmask;
`ifdef SRAMGEN_X_ON_WRITE_EN
            dout_d = 'x;
`else
            dout_d = dout_q;
`endif
          end else begin
            dout_d = mem[addr];
          end
        end
      end
      default: state_d = CLEAR;
    endcase

    // The reset edge must never touch the array, whatever the state.
    if (rst) begin
      mem_we = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      dout_q     <= dout_d;
    end
  end

  // NOTE: the array has no reset; the CLEAR sequence zero-fills it instead.
  always_ff @(posedge clk) begin
    for (int g = 0; g < WMASK_WIDTH; g++) begin
      if (mem_we[g]) begin
        mem[mem_addr][g*WG +: WG] <= mem_wdata[g*WG +: WG];
      end
    end
  end

  assign dout = dout_q;
  assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_sramgen_sram_masked_v2.sv
// Directed self-checking bench for sramgen_sram_masked_v2 (default and 64x256x8 instances).
module tb_sramgen_sram_masked_v2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  wmask = '0;
  logic [4:0]  addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        busy;

  logic        p_rst = 1'b1;
  logic        p_en = 1'b0;
  logic        p_we = 1'b0;
  logic [7:0]  p_wmask = '0;
  logic [7:0]  p_addr = '0;
  logic [63:0] p_din = '0;
  logic [63:0] p_dout;
  logic        p_busy;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  sramgen_sram_masked_v2 dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .wmask(wmask),
    .addr(addr), .din(din), .dout(dout), .busy(busy)
  );

  sramgen_sram_masked_v2 #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .WMASK_WIDTH(8)) dut_p (
    .clk(clk), .rst(p_rst), .en(p_en), .we(p_we), .wmask(p_wmask),
    .addr(p_addr), .din(p_din), .dout(p_dout), .busy(p_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 1000) begin
      tick;
      n++;
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    en = 1'b1; we = 1'b1; addr = a; din = d; wmask = m;
    tick;
    en = 1'b0; we = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a);
    en = 1'b1; we = 1'b0; addr = a;
    tick;
    en = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    tick;
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL reset_busy got %b want 1", busy); end
    n_cmp++; if (dout !== 32'h0) begin n_mis++; $display("FAIL reset_dout got %h want 00000000", dout); end
    tick;
    rst = 1'b0;
    count_busy(n);
    n_cmp++; if (n !== 32) begin n_mis++; $display("FAIL clear_len got %0d want 32", n); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL busy_after_clear got %b want 0", busy); end
  endtask

  task automatic test_clear_reads;
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a));
      n_cmp++; if (dout !== 32'h0) begin n_mis++; $display("FAIL clear_read[%0d] got %h want 00000000", a, dout); end
    end
  endtask

  task automatic test_masked_write;
    do_write(5'd3, 32'hFFFF_FFFF, 4'hF);
    do_write(5'd3, 32'h1234_5678, 4'b0101);
    do_read(5'd3);
    n_cmp++; if (dout !== 32'hFF34_FF78) begin n_mis++; $display("FAIL masked_write got %h want ff34ff78", dout); end
    // Zero mask must leave the word alone; read issued straight after the write.
    do_write(5'd3, 32'h0000_0000, 4'b0000);
    do_read(5'd3);
    n_cmp++; if (dout !== 32'hFF34_FF78) begin n_mis++; $display("FAIL zero_mask got %h want ff34ff78", dout); end
    do_write(5'd3, 32'hAB00_00CD, 4'b1001);
    do_read(5'd3);
    n_cmp++; if (dout !== 32'hAB34_FFCD) begin n_mis++; $display("FAIL back_to_back got %h want ab34ffcd", dout); end
    do_read(5'd4);
    n_cmp++; if (dout !== 32'h0) begin n_mis++; $display("FAIL neighbour_addr got %h want 00000000", dout); end
  endtask

  task automatic test_write_hold;
    do_write(5'd5, 32'hA5A5_A5A5, 4'hF);
    do_read(5'd5);
    n_cmp++; if (dout !== 32'hA5A5_A5A5) begin n_mis++; $display("FAIL hold_setup got %h want a5a5a5a5", dout); end
    do_write(5'd6, 32'h0F0F_1234, 4'hF);
`ifdef SRAMGEN_X_ON_WRITE_EN
    n_cmp++; if (dout !== 32'hxxxx_xxxx) begin n_mis++; $display("FAIL write_dout got %h want xxxxxxxx", dout); end
`else
    n_cmp++; if (dout !== 32'hA5A5_A5A5) begin n_mis++; $display("FAIL write_dout got %h want a5a5a5a5", dout); end
`endif
    do_read(5'd5);
    addr = 5'd6;
    tick;
    n_cmp++; if (dout !== 32'hA5A5_A5A5) begin n_mis++; $display("FAIL en_low_hold got %h want a5a5a5a5", dout); end
    do_read(5'd6);
    n_cmp++; if (dout !== 32'h0F0F_1234) begin n_mis++; $display("FAIL write_addr6 got %h want 0f0f1234", dout); end
  endtask

  task automatic test_ignore_busy;
    int n;
    // Reset from IDLE with a non-zero dout must zero it.
    rst = 1'b1;
    en = 1'b1; we = 1'b1; addr = 5'd7; din = 32'hDEAD_BEEF; wmask = 4'hF;
    tick;
    n_cmp++; if (dout !== 32'h0) begin n_mis++; $display("FAIL idle_reset_dout got %h want 00000000", dout); end
    rst = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      if (dout !== 32'h0) begin n_mis++; $display("FAIL busy_dout got %h want 00000000", dout); end
      n_cmp++;
      tick;
      n++;
    end
    en = 1'b0; we = 1'b0;
    n_cmp++; if (n !== 32) begin n_mis++; $display("FAIL ignore_clear_len got %0d want 32", n); end
    do_read(5'd7);
    n_cmp++; if (dout !== 32'h0) begin n_mis++; $display("FAIL ignore_busy got %h want 00000000", dout); end
  endtask

  task automatic test_reset_mid_clear;
    int n;
    do_write(5'd31, 32'h5555_5555, 4'hF);
    do_read(5'd31);
    n_cmp++; if (dout !== 32'h5555_5555) begin n_mis++; $display("FAIL mid_setup got %h want 55555555", dout); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    repeat (10) tick;
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL mid_busy got %b want 1", busy); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    count_busy(n);
    n_cmp++; if (n !== 32) begin n_mis++; $display("FAIL mid_clear_len got %0d want 32", n); end
    do_read(5'd31);
    n_cmp++; if (dout !== 32'h0) begin n_mis++; $display("FAIL mid_addr31 got %h want 00000000", dout); end
  endtask

  task automatic test_param_sweep;
    int n;
    p_rst = 1'b1;
    tick;
    tick;
    p_rst = 1'b0;
    n = 0;
    while (p_busy && n < 1000) begin
      tick;
      n++;
    end
    n_cmp++; if (n !== 256) begin n_mis++; $display("FAIL p_clear_len got %0d want 256", n); end
    p_en = 1'b1; p_we = 1'b1; p_addr = 8'd255; p_din = 64'h0123_4567_89AB_CDEF; p_wmask = 8'hFF;
    tick;
    p_din = 64'hAAAA_AAAA_AAAA_AAAA; p_wmask = 8'h80;
    tick;
    p_we = 1'b0;
    tick;
    p_en = 1'b0;
    n_cmp++; if (p_dout !== 64'hAA23_4567_89AB_CDEF) begin n_mis++; $display("FAIL p_byte_mask got %h want aa23456789abcdef", p_dout); end
    p_en = 1'b1; p_addr = 8'd254;
    tick;
    p_en = 1'b0;
    n_cmp++; if (p_dout !== 64'h0) begin n_mis++; $display("FAIL p_addr254 got %h want 0", p_dout); end
  endtask

  initial begin
    test_reset;
    test_clear_reads;
    test_masked_write;
    test_write_hold;
    test_ignore_busy;
    test_reset_mid_clear;
    test_param_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sramgen_sram_masked_v2.md
SRAMGEN_SRAM_MASKED_V2 -- requirements
Module: sramgen_sram_masked_v2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning address width; RAM_DEPTH = 1<<ADDR_WIDTH words (derived, not overridable).
REQ-003 The block SHALL have parameter WMASK_WIDTH, default 4, meaning number of write-mask groups; group width WG = DATA_WIDTH/WMASK_WIDTH.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, with synchronous active-high reset.
REQ-006 The block SHALL have port en, input, 1, access enable; no read or write when low.
REQ-007 The block SHALL have port we, input, 1, 1 = write, 0 = read, qualified by en.
REQ-008 The block SHALL have port wmask, input, WMASK_WIDTH, per-group write enable.
REQ-009 The block SHALL have port addr, input, ADDR_WIDTH, word address.
REQ-010 The block SHALL have port din, input, DATA_WIDTH, write data.
REQ-011 The block SHALL have port dout, output, DATA_WIDTH, registered read data.
REQ-012 The block SHALL have port busy, output, 1, high while the post-reset clear sequence runs.

Function
REQ-013 The block SHALL implement FSM states CLEAR and IDLE: CLEAR -> IDLE after the last clear write; IDLE -> CLEAR only on rst.
REQ-014 In CLEAR the block SHALL write all-zero to mem[clr_addr] each non-reset cycle and increment clr_addr; it SHALL leave CLEAR on the cycle it writes address RAM_DEPTH-1.
REQ-015 busy SHALL be 1 in CLEAR and 0 in IDLE, so it stays high for exactly RAM_DEPTH cycles after rst deasserts.
REQ-016 While busy=1 the block SHALL ignore en/we/wmask/addr/din, and dout SHALL hold 0.
REQ-017 In IDLE, a read (en=1, we=0) SHALL present mem[addr] on dout after the next rising edge (1-cycle latency).
REQ-018 In IDLE, a write (en=1, we=1) SHALL update bits [g*WG +: WG] of mem[addr] from din only for groups g with wmask[g]=1; the other groups SHALL keep their value.
REQ-019 A write with wmask = 0 SHALL leave memory unchanged; dout SHALL still follow REQ-027/028.
REQ-020 With en=0, dout SHALL hold its previous value and memory SHALL be unchanged.
REQ-021 A read of an address written in the previous cycle SHALL return the newly merged data; there is no read-write bypass within a single cycle.
REQ-022 The design SHALL be rejected at elaboration with a fatal error if DATA_WIDTH % WMASK_WIDTH != 0 or WMASK_WIDTH < 1.

Reset
REQ-023 While rst=1 the block SHALL force state to CLEAR, clr_addr to 0, dout to 0 and busy to 1; memory SHALL not be written during the rst cycle.
REQ-024 Asserting rst mid-CLEAR SHALL restart the clear sequence at address 0.
REQ-025 Asserting rst in IDLE SHALL abandon any access on that edge, and the block SHALL re-run the full clear.
REQ-026 Memory contents before the first reset SHALL be X in simulation; no initial zero-fill SHALL be applied.

Configuration
REQ-027 With macro SRAMGEN_X_ON_WRITE_EN defined, dout SHALL become all-X on every IDLE write cycle, to model arbitrary output during write.
REQ-028 Without SRAMGEN_X_ON_WRITE_EN, dout SHALL hold its previous value on write cycles; all other behaviour SHALL be identical.

Verification
REQ-029 Clear sequence: rst high 2 cycles then low -> busy=1 for exactly 32 cycles, then 0; a read of any address 0..31 returns 0x00000000.
REQ-030 Masked write: write 0xFFFFFFFF to addr 3 with mask 4'hF, then 0x12345678 with mask 4'b0101, then read addr 3 -> dout = 0xFF34FF78 one cycle after the read.
REQ-031 Ignore while busy: during clear, drive en=1, we=1, addr 7, din 0xDEADBEEF, mask 4'hF -> after busy falls, a read of addr 7 returns 0x00000000.
REQ-032 Reset mid-clear: assert rst at clear cycle 10 for 1 cycle -> busy stays high for 32 further cycles after deassertion; addr 31 reads 0.
REQ-033 Write/hold output: read addr 5 (value 0xA5A5A5A5), then write addr 6 -> dout is 0xA5A5A5A5 on the write cycle without the macro and all-X with SRAMGEN_X_ON_WRITE_EN; en=0 on the next cycle keeps dout unchanged.
REQ-034 Parameter sweep: DATA_WIDTH=64, ADDR_WIDTH=8, WMASK_WIDTH=8 -> busy lasts 256 cycles, and a byte-masked write to addr 255 with mask 8'h80 changes only bits [63:56].
